// File: rtl/sys_defs.sv
// Shared definitions for the reservation-station slice: default sizes and the
// per-entry record held by each rs_entry.
package sys_defs;

  localparam int DEF_RS_SIZE   = 4;
  localparam int DEF_TAG_W     = 6;
  localparam int DEF_PAYLOAD_W = 32;

  typedef struct packed {
    logic                     valid;
    logic [DEF_TAG_W-1:0]     tag1;
    logic                     rdy1;
    logic [DEF_TAG_W-1:0]     tag2;
    logic                     rdy2;
    logic [DEF_PAYLOAD_W-1:0] payload;
  } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: stores a dispatched instruction, snoops the CDB
// for its two source tags, and is cleared on issue or flush.
module rs_entry
  import sys_defs::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DEF_PAYLOAD_W-1:0] wr_payload,
  input  logic [DEF_TAG_W-1:0]     wr_tag1,
  input  logic                     wr_rdy1,
  input  logic [DEF_TAG_W-1:0]     wr_tag2,
  input  logic                     wr_rdy2,
  input  logic                     cdb_valid,
  input  logic [DEF_TAG_W-1:0]     cdb_tag,
  input  logic                     clr,
  output rs_entry_t                entry
);

  logic bypass1;
  logic bypass2;

  // A broadcast in the dispatch cycle would otherwise be missed by the new entry.
  assign bypass1 = cdb_valid && (cdb_tag == wr_tag1);
  assign bypass2 = cdb_valid && (cdb_tag == wr_tag2);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entry <= '0;
    end else if (flush) begin
      entry.valid <= 1'b0;
    end else if (wr_en) begin
      entry.valid   <= 1'b1;
      entry.tag1    <= wr_tag1;
      entry.rdy1    <= wr_rdy1 | bypass1;
      entry.tag2    <= wr_tag2;
      entry.rdy2    <= wr_rdy2 | bypass2;
      entry.payload <= wr_payload;
    end else if (clr) begin
      entry.valid <= 1'b0;
    end else if (entry.valid && cdb_valid) begin
      if (cdb_tag == entry.tag1) entry.rdy1 <= 1'b1;
      if (cdb_tag == entry.tag2) entry.rdy2 <= 1'b1;
    end
  end

endmodule

// File: rtl/rs_wakeup_select.sv
// Reservation-station entry bank: dispatch into the lowest free slot, CDB wakeup,
// ready vector out to the selector, and one-hot grant into a valid/ready issue register.
module rs_wakeup_select
  import sys_defs::*;
#(
  parameter int RS_SIZE   = DEF_RS_SIZE,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [PAYLOAD_W-1:0]       disp_payload,
  input  logic [TAG_W-1:0]           disp_tag1,
  input  logic                       disp_rdy1,
  input  logic [TAG_W-1:0]           disp_tag2,
  input  logic                       disp_rdy2,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  output logic [RS_SIZE-1:0]         sel_req,
  output logic                       sel_en,
  input  logic [RS_SIZE-1:0]         sel_gnt,
  output logic                       iss_valid,
  output logic [PAYLOAD_W-1:0]       iss_payload,
  input  logic                       iss_ready,
  output logic [$clog2(RS_SIZE)+1-1:0] free_count
);

  localparam int CNT_W = $clog2(RS_SIZE) + 1;

  rs_entry_t              ent [RS_SIZE];
  logic [RS_SIZE-1:0]     freeVec;
  logic [RS_SIZE-1:0]     allocVec;
  logic [RS_SIZE-1:0]     wrVec;
  logic [RS_SIZE-1:0]     clrVec;
  logic                   dispFire;
  logic                   gntOneHot;
  logic                   gntTake;
  logic [PAYLOAD_W-1:0]   issNext;
  logic                   allocFound;
  logic [CNT_W-1:0]       freeCnt;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      freeVec[i] = ~ent[i].valid;
      sel_req[i] = ent[i].valid & ent[i].rdy1 & ent[i].rdy2;
    end
  end

  // Lowest-index free slot; freeVec is registered so a slot vacated by this
  // cycle's issue only becomes allocatable next cycle.
  always_comb begin
    allocVec   = '0;
    allocFound = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (freeVec[i] && !allocFound) begin
        allocVec[i] = 1'b1;
        allocFound  = 1'b1;
      end
    end
  end

  always_comb begin
    freeCnt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      freeCnt = freeCnt + CNT_W'(freeVec[i]);
    end
  end

  assign free_count = freeCnt;
  assign disp_ready = |freeVec;
  assign dispFire   = disp_valid && disp_ready;
  assign sel_en     = ~iss_valid | iss_ready;

  // Malformed grants (multi-hot, or to a non-requesting slot) are dropped whole.
  assign gntOneHot = (sel_gnt != '0) && ((sel_gnt & (sel_gnt - RS_SIZE'(1))) == '0);
  assign gntTake   = sel_en && gntOneHot && ((sel_gnt & ~sel_req) == '0);
  assign wrVec     = dispFire ? allocVec : '0;
  assign clrVec    = gntTake ? sel_gnt : '0;

  always_comb begin
    issNext = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (sel_gnt[i]) issNext = issNext | ent[i].payload;
    end
  end

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_entry
    rs_entry u_entry (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .wr_en      (wrVec[g]),
      .wr_payload (disp_payload),
      .wr_tag1    (disp_tag1),
      .wr_rdy1    (disp_rdy1),
      .wr_tag2    (disp_tag2),
      .wr_rdy2    (disp_rdy2),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .clr        (clrVec[g]),
      .entry      (ent[g])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iss_valid   <= 1'b0;
      iss_payload <= '0;
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (gntTake) begin
      iss_valid   <= 1'b1;
      iss_payload <= issNext;
    end else if (iss_ready) begin
      iss_valid <= 1'b0;
    end
  end

endmodule
